run_sequencer: RTL and testbench
================================

RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameter NUM_PROGS, default 3: number of programs launched per sequence (1..4).
REQ-002 Parameter START_CYCLES, default 1: cycles Start is held high per launch (1..15).
REQ-003 Parameter TIMEOUT_CYCLES, default 65535: maximum cycles to wait for Ack per program.
REQ-004 Clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Reset  input  1  synchronous, active-low reset.
REQ-006 Go  input  1  one-cycle request to run the full program sequence; ignored unless idle.
REQ-007 Ack  input  1  core done flag; level signal, dropped by the core after Start.
REQ-008 Start  output  1  launch strobe to the core.
REQ-009 ProgIdx  output  2  index of the current or last program (0..NUM_PROGS-1).
REQ-010 CycleCount  output  16  cycles measured for the last finished program.
REQ-011 CountValid  output  1  one-cycle pulse when CycleCount and ProgIdx hold a new result.
REQ-012 Busy  output  1  high from Go acceptance until the sequence ends.
REQ-013 Done  output  1  one-cycle pulse when the last program finishes or times out.
REQ-014 TimedOut  output  1  sticky flag: some program in the sequence hit the timeout.

Function
REQ-015 States: IDLE, LAUNCH, ARM, WAIT, RECORD, FINISH.
REQ-016 IDLE: Go=1 -> LAUNCH; ProgIdx<=0; TimedOut<=0; Busy goes high in the next cycle.
REQ-017 LAUNCH: Start=1 for exactly START_CYCLES cycles, then -> ARM; cycle counter cleared on entry.
REQ-018 ARM: Start=0; wait for Ack=0 (stale done level from the previous run), then -> WAIT; counter runs.
REQ-019 WAIT: Ack sampled 1 -> RECORD; counter increments every cycle spent in ARM and WAIT.
REQ-020 CycleCount = cycles from the first LAUNCH cycle up to and including the cycle Ack is sampled high.
REQ-021 Counter saturates at 16'hFFFF and never wraps.
REQ-022 RECORD: CountValid=1 for one cycle; then ProgIdx==NUM_PROGS-1 -> FINISH, else ProgIdx+1 and -> LAUNCH.
REQ-023 FINISH: Done=1 for one cycle; Busy=0 from the next cycle; -> IDLE.
REQ-024 Go while Busy is ignored and does not queue.
REQ-025 Go and Ack high in the same IDLE cycle: Go is accepted; the stale Ack is handled by ARM.
REQ-026 Start is never high outside LAUNCH.

Reset
REQ-027 Reset=0 at a clock edge -> IDLE; Start=0, ProgIdx=0, CycleCount=0, CountValid=0, Busy=0, Done=0, TimedOut=0.
REQ-028 Reset mid-sequence aborts immediately: no CountValid or Done pulse; Start drops at that edge.

Configuration
REQ-029 With macro RUN_SEQ_TIMEOUT_EN defined: counter reaching TIMEOUT_CYCLES in ARM or WAIT sets TimedOut and forces RECORD, reporting CycleCount=TIMEOUT_CYCLES.
REQ-030 Without RUN_SEQ_TIMEOUT_EN: no timeout logic; TimedOut is tied to 0 and ARM/WAIT wait indefinitely.

Structure
REQ-031 Package run_seq_pkg holds the state enum type, CNT_W=16, and PROG_W=2.
REQ-032 Sub-module sat_counter: a 16-bit clear/enable saturating counter with a terminal-count output, used for both the Start hold time and the cycle measurement.

Verification
REQ-033 Reset low for 2 cycles, outputs sampled -> every output is 0 and the FSM is IDLE.
REQ-034 Go pulse; core model asserts Ack 10 cycles after Start falls, three times -> three CountValid pulses with ProgIdx 0,1,2, each CycleCount=11, then Done with Busy falling.
REQ-035 Ack held high from the previous run when Start pulses -> no early completion; ARM waits for Ack=0, then the next Ack rise is counted.
REQ-036 Go pulsed repeatedly while Busy -> exactly one sequence runs (three CountValid pulses, one Done).
REQ-037 RUN_SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=20 and Ack never rising -> CountValid with CycleCount=20, TimedOut=1, and the sequence continues to ProgIdx 1.
REQ-038 Reset asserted during WAIT of ProgIdx 1 -> next edge gives IDLE and all outputs 0; a following Go restarts at ProgIdx 0.

Source files
------------

// File: rtl/run_seq_pkg.sv
// Shared types and widths for the run sequencer and its saturating counter.
package run_seq_pkg;

  localparam int CNT_W  = 16;
  localparam int PROG_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_ARM,
    ST_WAIT,
    ST_RECORD,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/run_sequencer_counter.sv
// Clear/enable up-counter that sticks at all-ones; o_tc flags count == i_term.
module sat_counter
  import run_seq_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_term,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == i_term);

endmodule

// File: rtl/run_sequencer.sv
// Launches NUM_PROGS programs on a core in turn and measures each run in cycles.
// Optional per-program timeout is built only when RUN_SEQ_TIMEOUT_EN is defined.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int NUM_PROGS      = 3,
  parameter int START_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_go,
  input  logic              i_ack,
  output logic              o_start,
  output logic [PROG_W-1:0] o_prog_idx,
  output logic [CNT_W-1:0]  o_cycle_count,
  output logic              o_count_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timed_out
);

`ifdef RUN_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam logic [PROG_W-1:0] LAST_PROG = PROG_W'(NUM_PROGS - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(START_CYCLES - 1);
  // Without a timeout the terminal count marks saturation, so the report pins at all-ones.
  localparam logic [CNT_W-1:0]  TERM      = TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '1;
  localparam logic [CNT_W-1:0]  TC_REPORT = TMO_EN ? CNT_W'(TIMEOUT_CYCLES) : '1;

  state_t            r_state;
  logic              r_start;
  logic [PROG_W-1:0] r_prog;
  logic [CNT_W-1:0]  r_cycle_count;
  logic              r_count_valid;
  logic              r_busy;
  logic              r_done;

  logic [CNT_W-1:0]  w_cnt;
  logic              w_tc;
  logic              w_clr;
  logic              w_en;
  logic              w_timeout;
  logic              w_record;
  logic [CNT_W-1:0]  w_cnt_incl;

  assign w_clr = ((r_state == ST_IDLE) && i_go) ||
                 ((r_state == ST_RECORD) && (r_prog != LAST_PROG));
  assign w_en  = (r_state == ST_LAUNCH) || (r_state == ST_ARM) || (r_state == ST_WAIT);

  sat_counter u_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .i_term  (TERM),
    .o_count (w_cnt),
    .o_tc    (w_tc)
  );

`ifdef RUN_SEQ_TIMEOUT_EN
  logic r_timed_out;

  // A genuine Ack in the terminal cycle wins over the timeout.
  assign w_timeout = ((r_state == ST_ARM) || (r_state == ST_WAIT)) && w_tc &&
                     !((r_state == ST_WAIT) && i_ack);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_timed_out <= 1'b0;
    end else if ((r_state == ST_IDLE) && i_go) begin
      r_timed_out <= 1'b0;
    end else if (w_timeout) begin
      r_timed_out <= 1'b1;
    end
  end

  assign o_timed_out = r_timed_out;
`else
  assign w_timeout   = 1'b0;
  assign o_timed_out = 1'b0;
`endif

  assign w_record   = ((r_state == ST_WAIT) && i_ack) || w_timeout;
  // The measured value includes the cycle in which Ack is sampled.
  assign w_cnt_incl = w_tc ? TC_REPORT : w_cnt + 1'b1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_start       <= 1'b0;
      r_prog        <= '0;
      r_cycle_count <= '0;
      r_count_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_count_valid <= 1'b0;
      r_done        <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_go) begin
            r_state <= ST_LAUNCH;
            r_start <= 1'b1;
            r_prog  <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          if (w_cnt == HOLD_LAST) begin
            r_state <= ST_ARM;
            r_start <= 1'b0;
          end
        end
        ST_ARM, ST_WAIT: begin
          if (w_record) begin
            r_state       <= ST_RECORD;
            r_count_valid <= 1'b1;
            r_cycle_count <= w_cnt_incl;
          end else if ((r_state == ST_ARM) && !i_ack) begin
            r_state <= ST_WAIT;
          end
        end
        ST_RECORD: begin
          if (r_prog == LAST_PROG) begin
            r_state <= ST_FINISH;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_LAUNCH;
            r_start <= 1'b1;
            r_prog  <= r_prog + 1'b1;
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_start <= 1'b0;
        end
      endcase
    end
  end

  assign o_start       = r_start;
  assign o_prog_idx    = r_prog;
  assign o_cycle_count = r_cycle_count;
  assign o_count_valid = r_count_valid;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: lockstep timeline model of each sequence with randomized Ack timing.
module tb_run_sequencer;

  localparam int NP = 3;
  localparam int SC = 1;
`ifdef RUN_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
  localparam int TMO    = 20;
`else
  localparam bit TMO_EN = 1'b0;
  localparam int TMO    = 65535;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go;
  logic        ack;
  logic        o_start;
  logic [1:0]  o_prog_idx;
  logic [15:0] o_cycle_count;
  logic        o_count_valid;
  logic        o_busy;
  logic        o_done;
  logic        o_timed_out;

  always #5 clk = ~clk;

  run_sequencer #(
    .NUM_PROGS      (NP),
    .START_CYCLES   (SC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_go          (go),
    .i_ack         (ack),
    .o_start       (o_start),
    .o_prog_idx    (o_prog_idx),
    .o_cycle_count (o_cycle_count),
    .o_count_valid (o_count_valid),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_timed_out   (o_timed_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic        e_start, e_busy, e_cv, e_done, e_to;
  logic [1:0]  e_prog;
  logic [15:0] e_cc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare this cycle's outputs against the model, then drive this cycle's inputs.
  task automatic tick(input logic go_v, input logic ack_v);
    @(negedge clk);
    check_eq("start",       32'(o_start),       32'(e_start));
    check_eq("busy",        32'(o_busy),        32'(e_busy));
    check_eq("count_valid", 32'(o_count_valid), 32'(e_cv));
    check_eq("done",        32'(o_done),        32'(e_done));
    check_eq("timed_out",   32'(o_timed_out),   32'(e_to));
    check_eq("prog_idx",    32'(o_prog_idx),    32'(e_prog));
    check_eq("cycle_count", 32'(o_cycle_count), 32'(e_cc));
    go  = go_v;
    ack = ack_v;
  endtask

  function automatic logic rnd_go(input bit spam);
    return spam && ($urandom_range(0, 1) == 1);
  endfunction

  // mode 0 random, 1 fixed 11-cycle runs, 2 very long first run, 3 Go hammered, 4 abort-friendly.
  task automatic run_seq(input int mode, input logic go_ack, input int abort_prog);
    int   hold, low, r, rrec;
    bit   tmo, spam;
    logic lvl, ack_c;
    spam = (mode == 3) || ((mode == 0) && ($urandom_range(0, 1) == 1));
    lvl  = go_ack;
    tick(1'b1, lvl);
    e_busy = 1'b1;
    e_to   = 1'b0;
    for (int p = 0; p < NP; p++) begin
      e_prog = 2'(p);
      hold   = (mode == 0) ? $urandom_range(0, 4) : 0;
      case (mode)
        1:       low = 9;
        2:       low = (p == 0) ? 40 : $urandom_range(1, 12);
        4:       low = 8;
        default: low = ($urandom_range(0, 5) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 12);
      endcase
      // Start for SC cycles, stale level for hold cycles, low for low cycles, then Ack rises.
      r    = SC + hold + low + 1;
      tmo  = TMO_EN && (r > TMO);
      rrec = tmo ? TMO : r;
      for (int c = 1; c <= rrec; c++) begin
        e_start = (c <= SC);
        e_cv    = 1'b0;
        e_done  = 1'b0;
        if (c <= SC + hold) ack_c = lvl;
        else if (c < r)     ack_c = 1'b0;
        else                ack_c = 1'b1;
        tick(rnd_go(spam), ack_c);
        if ((p == abort_prog) && (c == SC + hold + 3)) begin
          rst_n   = 1'b0;
          e_start = 1'b0; e_busy = 1'b0; e_cv = 1'b0; e_done = 1'b0;
          e_to    = 1'b0; e_prog = 2'd0; e_cc = 16'd0;
          tick(1'b0, 1'b0);
          rst_n = 1'b1;
          return;
        end
      end
      e_start = 1'b0;
      e_cv    = 1'b1;
      e_cc    = 16'(rrec);
      if (tmo) e_to = 1'b1;
      lvl = (mode == 1) ? 1'b1 : logic'($urandom_range(0, 1));
      tick(rnd_go(spam), lvl);
      e_cv = 1'b0;
    end
    e_done = 1'b1;
    tick(rnd_go(spam), lvl);
    e_done = 1'b0;
    e_busy = 1'b0;
    tick(1'b0, lvl);
  endtask

  initial begin
    rst_n = 1'b0;
    go    = 1'b0;
    ack   = 1'b0;
    e_start = 1'b0; e_busy = 1'b0; e_cv = 1'b0; e_done = 1'b0;
    e_to    = 1'b0; e_prog = 2'd0; e_cc = 16'd0;
    repeat (2) @(posedge clk);
    tick(1'b0, 1'b0);
    rst_n = 1'b1;

    run_seq(1, 1'b0, -1);
    run_seq(1, 1'b1, -1);
    run_seq(3, 1'b0, -1);
    run_seq(2, 1'b0, -1);
    run_seq(4, 1'b0, 1);
    run_seq(1, 1'b0, -1);
    run_seq(4, 1'b1, 0);
    for (int i = 0; i < 40; i++) begin
      run_seq(0, logic'($urandom_range(0, 1)), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
